// File: rtl/cdc_tx_arbiter.sv
// Round-robin arbiter that sequences requester payloads through one toggle/ack
// CDC handshake channel: accept, hold data for SETUP_CYC, toggle, await ack.
module cdc_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int SETUP_CYC   = 2,
  parameter int TIMEOUT_CYC = 1024,
  parameter int ID_WIDTH    = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [DATA_WIDTH-1:0]         xfer_data_o,
  output logic [ID_WIDTH-1:0]           grant_id_o,
  output logic                          xfer_req_tgl_o,
  input  logic                          xfer_ack_tgl_i,
  output logic                          busy_o,
  output logic                          timeout_o,
  output logic                          err_o
);

  localparam int SC_W = $clog2(SETUP_CYC + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int SW   = ID_WIDTH + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_WAIT} state_t;

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   ptr_q;
  logic [SC_W-1:0]       setup_cnt_q;
  logic [TO_W-1:0]       to_cnt_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [ID_WIDTH-1:0]   gid_q;
  logic                  tgl_q;
  logic                  timeout_q;
  logic                  err_q;

  logic [NUM_REQ-1:0]    pick_oh;
  logic [ID_WIDTH-1:0]   pick_id;
  logic                  pick_any;
  logic [SW-1:0]         sum;
  logic                  settle_done;
  logic                  ack_match;

  // First valid requester at or above the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    pick_oh  = '0;
    pick_id  = '0;
    pick_any = 1'b0;
    sum      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr_q} + SW'(i);
      if (sum >= SW'(NUM_REQ)) sum = sum - SW'(NUM_REQ);
      if (!pick_any && req_valid_i[sum[ID_WIDTH-1:0]]) begin
        pick_any = 1'b1;
        pick_id  = sum[ID_WIDTH-1:0];
      end
    end
    if (pick_any) pick_oh[pick_id] = 1'b1;
  end

  assign settle_done = (setup_cnt_q == SC_W'(SETUP_CYC - 1));
  assign ack_match   = (xfer_ack_tgl_i == tgl_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (pick_any)    state_d = ST_SETTLE;
      ST_SETTLE: if (settle_done) state_d = ST_WAIT;
      ST_WAIT:   if (ack_match)   state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q       <= '0;
      setup_cnt_q <= '0;
      to_cnt_q    <= '0;
      data_q      <= '0;
      gid_q       <= '0;
      tgl_q       <= 1'b0;
      timeout_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            data_q      <= req_data_i[int'(pick_id)*DATA_WIDTH +: DATA_WIDTH];
            gid_q       <= pick_id;
            ptr_q       <= (pick_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : pick_id + ID_WIDTH'(1);
            setup_cnt_q <= '0;
          end
        end
        ST_SETTLE: begin
          setup_cnt_q <= setup_cnt_q + SC_W'(1);
          if (settle_done) begin
            tgl_q    <= ~tgl_q;
            to_cnt_q <= '0;
          end
        end
        ST_WAIT: begin
          // A matching ack takes priority over a timeout on the same edge.
          if (!ack_match && to_cnt_q != TO_W'(TIMEOUT_CYC)) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
            if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
              timeout_q <= 1'b1;
              err_q     <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready_o    = (state_q == ST_IDLE) ? pick_oh : '0;
  assign xfer_data_o    = data_q;
  assign grant_id_o     = gid_q;
  assign xfer_req_tgl_o = tgl_q;
  assign busy_o         = (state_q != ST_IDLE);
  assign timeout_o      = timeout_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_cdc_tx_arbiter.sv
// Bench for cdc_tx_arbiter: vector table, directed corner sequences and random
// traffic compared against a transaction-level reference model.
module tb_cdc_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int SC = 2;
  localparam int TO = 8;
  localparam int IW = 2;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   xfer_data;
  logic [IW-1:0]   grant_id;
  logic            req_tgl;
  logic            ack_tgl;
  logic            busy;
  logic            timeout;
  logic            err;

  cdc_tx_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .SETUP_CYC(SC), .TIMEOUT_CYC(TO), .ID_WIDTH(IW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_ready_o(req_ready), .xfer_data_o(xfer_data), .grant_id_o(grant_id),
    .xfer_req_tgl_o(req_tgl), .xfer_ack_tgl_i(ack_tgl), .busy_o(busy),
    .timeout_o(timeout), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: transfer-level view (busy flag, edges since acceptance,
  // edges spent waiting for the ack).
  int            m_ptr, m_age, m_wcnt, m_gid;
  bit            m_busy, m_tgl, m_to, m_err;
  logic [DW-1:0] m_data;

  function automatic logic [N-1:0] m_ready(input logic [N-1:0] v);
    logic [N-1:0] r = '0;
    if (m_busy) return r;
    for (int k = 0; k < N; k++) begin
      int idx = (m_ptr + k) % N;
      if (((v >> idx) & 1) != 0) begin
        r = N'(1) << idx;
        return r;
      end
    end
    return r;
  endfunction

  task automatic model_edge(input logic r, input logic [N-1:0] v,
                            input logic [N*DW-1:0] d, input logic a);
    logic [N-1:0] rdy;
    if (r) begin
      m_ptr = 0; m_busy = 0; m_age = 0; m_wcnt = 0; m_gid = 0;
      m_tgl = 0; m_to = 0; m_err = 0; m_data = '0;
      return;
    end
    m_to = 0;
    if (!m_busy) begin
      rdy = m_ready(v);
      for (int k = 0; k < N; k++) begin
        if (((rdy >> k) & 1) != 0) begin
          m_data = DW'(d >> (k * DW));
          m_gid  = k;
          m_ptr  = (k + 1) % N;
          m_busy = 1;
          m_age  = 0;
        end
      end
    end else if (m_age < SC) begin
      m_age++;
      if (m_age == SC) begin
        m_tgl  = !m_tgl;
        m_wcnt = 0;
      end
    end else if (a == m_tgl) begin
      m_busy = 0;
    end else if (m_wcnt < TO) begin
      m_wcnt++;
      if (m_wcnt == TO) begin
        m_to  = 1;
        m_err = 1;
      end
    end
  endtask

  int ack_lat = 0;
  int ack_cnt = 0;
  bit new_grant;
  int n_grants = 0;

  // Destination emulation: echo the request toggle ack_lat cycles later.
  task automatic auto_ack();
    if (ack_lat > 0) begin
      if (m_tgl != ack_tgl) begin
        ack_cnt++;
        if (ack_cnt >= ack_lat) begin
          ack_tgl = m_tgl;
          ack_cnt = 0;
        end
      end else begin
        ack_cnt = 0;
      end
    end
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic step();
    bit was_busy;
    auto_ack();
    #1;
    check("ready", 32'(req_ready), 32'(m_ready(req_valid)));
    @(posedge clk);
    was_busy = m_busy;
    model_edge(rst, req_valid, req_data, ack_tgl);
    new_grant = m_busy && !was_busy;
    if (new_grant) n_grants++;
    #1;
    check("xfer_data", 32'(xfer_data), 32'(m_data));
    check("grant_id",  32'(grant_id),  32'(m_gid));
    check("req_tgl",   32'(req_tgl),   32'(m_tgl));
    check("timeout",   32'(timeout),   32'(m_to));
    check("err",       32'(err),       32'(m_err));
    check("busy",      32'(busy),      32'(m_busy));
    @(negedge clk);
  endtask

  int exp_q[$];

  task automatic grant_seq(input string tag);
    int budget = 300;
    int e;
    while (exp_q.size() > 0 && budget > 0) begin
      req_data = $urandom;
      step();
      budget--;
      if (new_grant) begin
        e = exp_q.pop_front();
        check({tag, "_gid"}, 32'(grant_id), 32'(e));
        check({tag, "_tgl_parity"}, 32'(req_tgl), 32'((n_grants - 1) % 2));
      end
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL %s_budget: %0d grants still outstanding, required 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; ack_tgl = 1'b0; ack_lat = 0; ack_cnt = 0;
    step();
    rst = 1'b0;
    n_grants = 0;
  endtask

  typedef struct {
    bit           rst;
    logic [N-1:0] v;
    logic         ack;
    logic [N-1:0] e_ready;
    bit           e_busy;
    int           e_gid;
    logic [7:0]   e_data;
    bit           e_tgl;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int pulses, pos;
    rst = 1'b1; req_valid = '0; req_data = '0; ack_tgl = 1'b0;
    m_ptr = 0; m_busy = 0; m_age = 0; m_wcnt = 0; m_gid = 0;
    m_tgl = 0; m_to = 0; m_err = 0; m_data = '0;

    //            rst   valid    ack   ready    busy  gid data   tgl
    tbl[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 0, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 2, 8'hA5, 1'b0};
    tbl[2]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 2, 8'hA5, 1'b0};
    tbl[3]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 2, 8'hA5, 1'b1};
    tbl[4]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2, 8'hA5, 1'b1};
    tbl[5]  = '{1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 0, 8'h3C, 1'b1};
    tbl[6]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 0, 8'h3C, 1'b1};
    tbl[7]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 0, 8'h3C, 1'b0};
    tbl[8]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 0, 8'h3C, 1'b0};
    tbl[9]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 0, 8'h3C, 1'b0};
    tbl[10] = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2, 8'hA5, 1'b0};
    tbl[11] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 2, 8'hA5, 1'b0};
    tbl[12] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 2, 8'hA5, 1'b1};
    tbl[13] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2, 8'hA5, 1'b1};

    @(negedge clk);
    req_data = 32'h44A5_223C;
    for (int i = 0; i < 14; i++) begin
      rst = tbl[i].rst; req_valid = tbl[i].v; ack_tgl = tbl[i].ack;
      #1;
      check($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].e_ready));
      step();
      check($sformatf("tbl%0d_busy", i), 32'(busy),      32'(tbl[i].e_busy));
      check($sformatf("tbl%0d_gid", i),  32'(grant_id),  32'(tbl[i].e_gid));
      check($sformatf("tbl%0d_data", i), 32'(xfer_data), 32'(tbl[i].e_data));
      check($sformatf("tbl%0d_tgl", i),  32'(req_tgl),   32'(tbl[i].e_tgl));
    end

    // Round robin with all requesters active, ack 3 cycles after each toggle.
    do_reset();
    ack_lat = 3;
    req_valid = 4'b1111;
    exp_q = '{0, 1, 2, 3, 0, 1};
    grant_seq("rr");

    // Pointer wrap and skip over idle requesters.
    exp_q = '{2, 3};
    grant_seq("wrap_pre");
    req_valid = 4'b1010;
    exp_q = '{1, 3, 1};
    grant_seq("wrap");

    // Timeout with the ack never returned, then a late matching ack.
    do_reset();
    req_valid = 4'b0001; step();
    req_valid = '0; step(); step();
    check("to_toggled", 32'(req_tgl), 32'(1));
    pulses = 0; pos = -1;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (timeout) begin pulses++; pos = c; end
    end
    check("to_pulses", 32'(pulses), 32'(1));
    check("to_pos", 32'(pos), 32'(8));
    check("to_err", 32'(err), 32'(1));
    check("to_busy", 32'(busy), 32'(1));
    ack_tgl = 1'b1; step();
    check("to_ack_busy", 32'(busy), 32'(0));
    check("to_ack_err", 32'(err), 32'(1));

    // Ack matching on the edge the timeout would fire.
    do_reset();
    req_valid = 4'b0010; step();
    req_valid = '0; step(); step();
    for (int c = 1; c <= 7; c++) step();
    ack_tgl = 1'b1; step();
    check("race_busy", 32'(busy), 32'(0));
    check("race_timeout", 32'(timeout), 32'(0));
    check("race_err", 32'(err), 32'(0));
    for (int c = 0; c < 4; c++) step();
    check("race_err_late", 32'(err), 32'(0));

    // Reset mid-WAIT after a timeout, then a spurious ack in IDLE.
    do_reset();
    req_valid = 4'b0100; req_data = 32'h00E7_0000; step();
    req_valid = '0; step(); step();
    for (int c = 0; c < 9; c++) step();
    check("rstw_err_pre", 32'(err), 32'(1));
    rst = 1'b1; step(); rst = 1'b0;
    check("rstw_data", 32'(xfer_data), 32'(0));
    check("rstw_gid", 32'(grant_id), 32'(0));
    check("rstw_tgl", 32'(req_tgl), 32'(0));
    check("rstw_err", 32'(err), 32'(0));
    check("rstw_busy", 32'(busy), 32'(0));
    ack_tgl = 1'b1; step();
    check("spur_busy", 32'(busy), 32'(0));
    check("spur_ready", 32'(req_ready), 32'(0));
    ack_tgl = 1'b0; step();

    // Random traffic with varying ack latency, spurious acks and resets.
    do_reset();
    ack_lat = 2;
    for (int i = 0; i < 3000; i++) begin
      req_valid = N'($urandom);
      req_data  = $urandom;
      rst       = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 31) == 0) ack_tgl = ~ack_tgl;
      step();
      if (new_grant) ack_lat = $urandom_range(1, 11);
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
